// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Writer side of the CPU program-RAM load port.  A byte stream arrives over a
// valid/ready handshake.  It begins with a word count N (1..2**ADDR_W),
// followed by N {HI, LO} byte pairs.  Each pair is assembled into one
// WORD_W-bit instruction word, which is written to RAM with a single-cycle
// WE pulse.  When the image has loaded cleanly, PC_ENABLE is released so the
// CPU starts executing from the loaded image.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When this macro is defined, one trailing checksum byte follows the last
//   word.  It must equal the XOR of every HI and LO byte of the load.  The
//   loader enters RUN on a match and ERROR on a mismatch.  When the macro is
//   undefined, the loader goes straight from the last write to RUN.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a load (level, sampled every cycle)
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader can accept a byte (transfer = in_valid & in_ready)
//   wa         out  RAM write address (holds the last address between writes)
//   wd         out  RAM write data    (holds the last data between writes)
//   we         out  RAM write enable, one-cycle pulse per word
//   pc_enable  out  CPU run enable
//   busy       out  load in progress
//   done       out  image loaded, CPU running
//   err        out  load aborted on a format or checksum error
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wa,
  output logic [WORD_W-1:0] wd,
  output logic              we,
  output logic              pc_enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  // The count byte is compared in 9 bits so that a 2**ADDR_W limit of 256
  // would still be representable.
  localparam logic [8:0]        MAX_WORDS = 9'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state;
  logic [ADDR_W:0]     word_count;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-9:0]   hi_bits;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          checksum;
`endif

  logic count_bad;
  logic last_word;

  // A count of zero, or a count above the RAM depth, aborts the load before
  // anything is written.
  assign count_bad = (in_data == 8'd0) || ({1'b0, in_data} > MAX_WORDS);

  // The word currently being written is the final one of the image.
  assign last_word = ({1'b0, addr} == (word_count - COUNT_ONE));

  // The whole loader lives in one registered FSM.  Every output is a
  // register, and it is updated on the transition into the state that owns
  // it.  That way in_ready, we, pc_enable and friends change exactly at the
  // state boundary, with no combinational decode path to the CPU or RAM.
  // The async reset drops we and pc_enable immediately.  RAM contents are
  // not touched, so a partial image stays as written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      we         <= 1'b0;
      pc_enable  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      word_count <= '0;
      addr       <= '0;
      hi_bits    <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= 8'd0;
`endif
    end else begin
      // A write pulse lasts exactly one cycle: the cycle spent in WRITE.
      we <= 1'b0;

      case (state)
        // Only start matters here.  Stream traffic is ignored.
        S_IDLE: begin
          if (start) begin
            state    <= S_COUNT;
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum <= 8'd0;
`endif
          end
        end

        // The first byte of the stream is the number of words.
        S_COUNT: begin
          if (in_valid) begin
            if (count_bad) begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              word_count <= in_data[ADDR_W:0];
              addr       <= '0;
              state      <= S_HI;
            end
          end
        end

        // The high byte must have bit 7 clear, because only bits
        // [WORD_W-9:0] exist in an instruction word.
        S_HI: begin
          if (in_valid) begin
            if (in_data[7]) begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              hi_bits  <= in_data[WORD_W-9:0];
              state    <= S_LO;
`ifdef LOADER_CHECKSUM_EN
              checksum <= checksum ^ in_data;
`endif
            end
          end
        end

        // The low byte completes the word.  The write strobe, address and
        // data are all registered here, so they are valid during the
        // following WRITE cycle.
        S_LO: begin
          if (in_valid) begin
            state    <= S_WRITE;
            in_ready <= 1'b0;
            we       <= 1'b1;
            wa       <= addr;
            wd       <= {hi_bits, in_data};
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum ^ in_data;
`endif
          end
        end

        // One dead cycle on the stream while the RAM write happens.  This
        // sets the peak rate of one word every three cycles.
        S_WRITE: begin
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state     <= S_CHECK;
            in_ready  <= 1'b1;
`else
            state     <= S_RUN;
            busy      <= 1'b0;
            pc_enable <= 1'b1;
            done      <= 1'b1;
`endif
          end else begin
            addr     <= addr + ADDR_ONE;
            state    <= S_HI;
            in_ready <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        // Trailing checksum byte.  On a mismatch, the words already written
        // stay in RAM, but the CPU is not released.
        S_CHECK: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == checksum) begin
              state     <= S_RUN;
              pc_enable <= 1'b1;
              done      <= 1'b1;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end
`endif

        // Starting a reload halts the CPU on the same edge, before any new
        // word can overwrite the image it is executing.
        S_RUN: begin
          if (start) begin
            state     <= S_COUNT;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            pc_enable <= 1'b0;
            done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum  <= 8'd0;
`endif
          end
        end

        S_ERROR: begin
          if (start) begin
            state    <= S_COUNT;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= 8'd0;
`endif
          end
        end

        // Unused encodings recover to a quiet idle.
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          pc_enable <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Testbench for program_loader.  Stream bytes are generated from random
// words.  The expected RAM writes are derived directly from the stream
// format: word i goes to address i, with data {HI[6:0], LO}.  A monitor
// records every WE pulse, so the recorded writes can be compared against
// that expectation.
// ---------------------------------------------------------------------------
module tb_program_loader;

  localparam int ADDR_W = 4;
  localparam int WORD_W = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] wa;
  logic [WORD_W-1:0] wd;
  logic              we;
  logic              pc_enable;
  logic              busy;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  // Writes recorded from the DUT, and writes predicted from the stream.
  logic [ADDR_W-1:0] mon_addr[$];
  logic [WORD_W-1:0] mon_data[$];
  int                mon_cyc[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [WORD_W-1:0] exp_data[$];

  program_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wa(wa), .wd(wd), .we(we),
    .pc_enable(pc_enable), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record each write pulse.  The stream must be closed while the write
  // is in progress.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      mon_addr.push_back(wa);
      mon_data.push_back(wd);
      mon_cyc.push_back(cycle);
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL write_ready: in_ready=%b during WE, required 0", in_ready);
      end
    end
  end

  // Offer one byte.  Optionally idle first for random stall cycles.  The
  // task returns on the negedge that follows the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    while (stall && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake_timeout: in_ready=%b after 50 cycles, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_queues();
    mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  // Random image of n words.  The checksum byte is appended when that
  // feature is built in.
  task automatic random_load(input int n, input bit stall);
    logic [7:0] hi, lo, chk;
    chk = 8'd0;
    clear_queues();
    pulse_start();
    send_byte(8'(n), stall);
    for (int i = 0; i < n; i++) begin
      hi = 8'($urandom_range(0, 127));
      lo = 8'($urandom_range(0, 255));
      chk = chk ^ hi ^ lo;
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back({hi[6:0], lo});
      send_byte(hi, stall);
      send_byte(lo, stall);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk, stall);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, we, pc_enable, busy, done, err} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b, required 000000",
               {in_ready, we, pc_enable, busy, done, err});
    end
    total++;
    if ({wa, wd} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_bus: wa=%h wd=%h, required 0", wa, wd);
    end
    rst = 1'b0;
    // With no start, idle ignores stream traffic.
    in_valid = 1'b1; in_data = 8'h05;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_ignore: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_load_n2();
    logic [7:0] chk;
    clear_queues();
    exp_addr.push_back(4'd0); exp_data.push_back(15'h7FFF);
    exp_addr.push_back(4'd1); exp_data.push_back(15'h0005);
    chk = 8'h7F ^ 8'hFF ^ 8'h00 ^ 8'h05;
    pulse_start();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL n2_busy: busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
    send_byte(8'h02, 1'b0);
    send_byte(8'h7F, 1'b0); send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk, 1'b0);
`endif
    repeat (2) @(negedge clk);
    total++;
    if (mon_addr.size() != exp_addr.size()) begin
      bad++;
      $display("[TB] FAIL n2_count: writes=%0d, required %0d", mon_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
      total++;
      if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
        bad++;
        $display("[TB] FAIL n2_word%0d: wa=%h wd=%h, required wa=%h wd=%h",
                 i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
      end
    end
    total++;
    if ({pc_enable, done, busy, err} !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL n2_run: pc_enable,done,busy,err=%b, required 1100",
               {pc_enable, done, busy, err});
    end
    total++;
    if (wa !== 4'd1 || wd !== 15'h0005) begin
      bad++;
      $display("[TB] FAIL n2_hold: wa=%h wd=%h, required 1 0005", wa, wd);
    end
  endtask

  task automatic test_bad_count();
    logic [7:0] counts [2];
    counts[0] = 8'h00;
    counts[1] = 8'h11;
    for (int k = 0; k < 2; k++) begin
      clear_queues();
      pulse_start();
      send_byte(counts[k], 1'b0);
      total++;
      if (err !== 1'b1 || pc_enable !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bad_count_%h: err=%b pc_enable=%b busy=%b, required 1 0 0",
                 counts[k], err, pc_enable, busy);
      end
      pulse_start();
      total++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bad_count_restart_%h: err=%b busy=%b, required 0 1",
                 counts[k], err, busy);
      end
      total++;
      if (mon_addr.size() != 0) begin
        bad++;
        $display("[TB] FAIL bad_count_nowrite_%h: writes=%0d, required 0", counts[k], mon_addr.size());
      end
    end
    // Return to a known idle state.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_format_error();
    clear_queues();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h80, 1'b0);
    total++;
    if (err !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL format_err: err=%b in_ready=%b, required 1 0", err, in_ready);
    end
    repeat (2) @(negedge clk);
    total++;
    if (mon_addr.size() != 0 || pc_enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL format_nowrite: writes=%0d pc_enable=%b, required 0 0",
               mon_addr.size(), pc_enable);
    end
  endtask

  task automatic test_stall_random();
    random_load(16, 1'b1);
    total++;
    if (mon_addr.size() != 16) begin
      bad++;
      $display("[TB] FAIL stall_count: writes=%0d, required 16", mon_addr.size());
    end
    for (int i = 0; i < 16 && i < mon_addr.size(); i++) begin
      total++;
      if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
        bad++;
        $display("[TB] FAIL stall_word%0d: wa=%h wd=%h, required wa=%h wd=%h",
                 i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
      end
    end
    total++;
    if (pc_enable !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_run: pc_enable=%b done=%b, required 1 1", pc_enable, done);
    end
  endtask

  // Two loads back to back with the stream never stalling.  Consecutive
  // writes must land exactly three cycles apart.
  task automatic test_back_to_back();
    for (int pass = 0; pass < 2; pass++) begin
      random_load($urandom_range(2, 16), 1'b0);
      total++;
      if (mon_addr.size() != exp_addr.size()) begin
        bad++;
        $display("[TB] FAIL b2b_count: writes=%0d, required %0d", mon_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
        total++;
        if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
          bad++;
          $display("[TB] FAIL b2b_word%0d: wa=%h wd=%h, required wa=%h wd=%h",
                   i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
        end
      end
      for (int i = 1; i < mon_cyc.size(); i++) begin
        total++;
        if (mon_cyc[i] - mon_cyc[i-1] != 3) begin
          bad++;
          $display("[TB] FAIL b2b_rate%0d: spacing=%0d, required 3", i, mon_cyc[i] - mon_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_reload_and_reset();
    random_load($urandom_range(1, 16), 1'b0);
    total++;
    if (pc_enable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reload_run: pc_enable=%b, required 1", pc_enable);
    end
    pulse_start();
    total++;
    if (pc_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reload_halt: pc_enable=%b done=%b busy=%b, required 0 0 1",
               pc_enable, done, busy);
    end
    // Apply reset asynchronously in the middle of the HI state.
    send_byte(8'h03, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, we, pc_enable, busy, done, err, wa, wd} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_midload: flags=%b wa=%h wd=%h, required all 0",
               {in_ready, we, pc_enable, busy, done, err}, wa, wd);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_queues();
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h26, 1'b0);
    @(negedge clk);
    total++;
    if (pc_enable !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL chk_good: pc_enable=%b err=%b, required 1 0", pc_enable, err);
    end
    clear_queues();
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h27, 1'b0);
    @(negedge clk);
    total++;
    if (err !== 1'b1 || pc_enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL chk_bad: err=%b pc_enable=%b, required 1 0", err, pc_enable);
    end
    total++;
    if (mon_data.size() != 1 || mon_data[0] !== 15'h1234) begin
      bad++;
      $display("[TB] FAIL chk_written: writes=%0d, required one write of 1234", mon_data.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_n2();
    test_bad_count();
    test_format_error();
    test_stall_random();
    test_back_to_back();
    test_reload_and_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
